// File: rtl/address_register_sequencer_pkg.sv
// Shared ARF control encodings: function codes, output selects,
// active-low register enable masks, sequencer states and the default stack top.
package arf_ctrl_pkg;

    // ARF function codes
    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    // ARF output select codes
    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_AR = 2'b10;
    localparam logic [1:0] SEL_SP = 2'b11;

    // Active-low register enables: bit2 = PC, bit1 = AR, bit0 = SP
    localparam logic [2:0] REG_NONE = 3'b111;
    localparam logic [2:0] REG_ALL  = 3'b000;
    localparam logic [2:0] REG_PC   = 3'b011;
    localparam logic [2:0] REG_AR   = 3'b101;
    localparam logic [2:0] REG_SP   = 3'b110;

    localparam logic [15:0] DEFAULT_STACK_TOP = 16'h00FF;

    typedef enum logic [2:0] {
        ST_INIT_CLR = 3'd0,
        ST_INIT_SP  = 3'd1,
        ST_IDLE     = 3'd2,
        ST_FETCH    = 3'd3,
        ST_PUSH     = 3'd4,
        ST_POP_INC  = 3'd5,
        ST_POP_ADDR = 3'd6,
        ST_LOAD     = 3'd7
    } state_t;

    // Map a load target code onto the register enable mask (00 and 01 both mean PC)
    function automatic logic [2:0] target_mask(input logic [1:0] target);
        logic [2:0] mask;
        case (target)
            2'b10:   mask = REG_AR;
            2'b11:   mask = REG_SP;
            default: mask = REG_PC;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/address_register_sequencer_if.sv
// Requester handshakes plus ARF control bus of the address register sequencer.
interface address_register_sequencer_if;

    logic        FetchReq;
    logic        FetchAck;
    logic        StackReq;
    logic        StackPop;
    logic        StackAck;
    logic        LoadReq;
    logic [1:0]  LoadTarget;
    logic [15:0] LoadData;
    logic        LoadAck;
    logic [15:0] ArfI;
    logic [2:0]  ArfRegSel;
    logic [2:0]  ArfFunSel;
    logic [1:0]  ArfOutCSel;
    logic [1:0]  ArfOutDSel;
    logic        AddrValid;
    logic        Busy;

    // Requesters and ARF observer side
    modport master (
        output FetchReq, StackReq, StackPop, LoadReq, LoadTarget, LoadData,
        input  FetchAck, StackAck, LoadAck, ArfI, ArfRegSel, ArfFunSel,
        input  ArfOutCSel, ArfOutDSel, AddrValid, Busy
    );

    // Sequencer side
    modport slave (
        input  FetchReq, StackReq, StackPop, LoadReq, LoadTarget, LoadData,
        output FetchAck, StackAck, LoadAck, ArfI, ArfRegSel, ArfFunSel,
        output ArfOutCSel, ArfOutDSel, AddrValid, Busy
    );

endinterface

// File: rtl/address_register_sequencer_arbiter.sv
// Three-way round-robin arbiter (0 = fetch, 1 = stack, 2 = load).
// Grant is combinational from req and the priority pointer; the pointer
// moves past the granted port when advance is asserted.
module rr_arbiter_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [2:0] grant
);

    logic [1:0] ptr;

    // Pick the first requesting port starting at the priority pointer
    always_comb begin
        grant = '0;
        case (ptr)
            2'd1: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd2: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

    // Move priority to the port following the one just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (advance) begin
            if      (grant[0]) ptr <= 2'd1;
            else if (grant[1]) ptr <= 2'd2;
            else if (grant[2]) ptr <= 2'd0;
        end
    end

endmodule

// File: rtl/address_register_sequencer.sv
// Moore sequencer driving an address register file (PC/AR/SP): initialises
// the registers, then serves fetch, stack push/pop and load requests chosen
// by a round-robin arbiter, one operation at a time with IDLE in between.
module address_register_sequencer
    import arf_ctrl_pkg::*;
#(
    parameter logic [15:0] STACK_TOP = DEFAULT_STACK_TOP
) (
    input logic                         Clock,
    input logic                         Reset,
    address_register_sequencer_if.slave bus
);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  req;
    logic [2:0]  grant;
    logic        advance;
    logic        pop_q;
    logic [1:0]  target_q;
    logic [15:0] data_q;

    assign req     = {bus.LoadReq, bus.StackReq, bus.FetchReq};
    assign advance = (state_q == ST_IDLE) && (|req);

    rr_arbiter_3 u_arbiter (
        .clk     (Clock),
        .rst_n   (Reset),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_INIT_CLR;
        else        state_q <= state_d;
    end

    // Capture the granted request's operands so later input changes are ignored
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pop_q    <= 1'b0;
            target_q <= '0;
            data_q   <= '0;
        end else if (advance) begin
            if (grant[1]) pop_q <= bus.StackPop;
            if (grant[2]) begin
                target_q <= bus.LoadTarget;
                data_q   <= bus.LoadData;
            end
        end
    end

    // Next-state selection; the stack direction comes straight from the input
    // at grant time since the latched copy is only valid from the next cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT_CLR: state_d = ST_INIT_SP;
            ST_INIT_SP:  state_d = ST_IDLE;
            ST_IDLE: begin
                if      (grant[0]) state_d = ST_FETCH;
                else if (grant[1]) state_d = bus.StackPop ? ST_POP_INC : ST_PUSH;
                else if (grant[2]) state_d = ST_LOAD;
            end
            ST_POP_INC:  state_d = ST_POP_ADDR;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and latched operands only
    always_comb begin
        bus.ArfRegSel  = REG_NONE;
        bus.ArfFunSel  = FUN_DEC;
        bus.ArfOutCSel = SEL_AR;
        bus.ArfOutDSel = SEL_PC;
        bus.ArfI       = '0;
        bus.FetchAck   = 1'b0;
        bus.StackAck   = 1'b0;
        bus.LoadAck    = 1'b0;
        bus.AddrValid  = 1'b0;
        bus.Busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_INIT_CLR: begin
                bus.ArfRegSel = REG_ALL;
                bus.ArfFunSel = FUN_CLR;
            end
            ST_INIT_SP: begin
                bus.ArfRegSel = REG_SP;
                bus.ArfFunSel = FUN_LOAD;
                bus.ArfI      = STACK_TOP;
            end
            ST_FETCH: begin
                bus.ArfOutDSel = SEL_PC;
                bus.AddrValid  = 1'b1;
                bus.ArfRegSel  = REG_PC;
                bus.ArfFunSel  = FUN_INC;
                bus.FetchAck   = 1'b1;
            end
            ST_PUSH: begin
                bus.ArfOutDSel = SEL_SP;
                bus.AddrValid  = 1'b1;
                bus.ArfRegSel  = REG_SP;
                bus.ArfFunSel  = FUN_DEC;
                bus.StackAck   = 1'b1;
            end
            ST_POP_INC: begin
                bus.ArfRegSel = REG_SP;
                bus.ArfFunSel = FUN_INC;
            end
            ST_POP_ADDR: begin
                bus.ArfOutDSel = SEL_SP;
                bus.AddrValid  = 1'b1;
                bus.StackAck   = 1'b1;
            end
            ST_LOAD: begin
                bus.ArfI      = data_q;
                bus.ArfFunSel = FUN_LOAD;
                bus.ArfRegSel = target_mask(target_q);
                bus.LoadAck   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/address_register_sequencer.md
ADDRESS_REGISTER_SEQUENCER -- requirements
Module: address_register_sequencer

Interface
REQ-001 SHALL have parameter STACK_TOP, default 16'h00FF, meaning SP value loaded at initialisation.
REQ-002 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports FetchReq (in, 1) and FetchAck (out, 1): fetch requester.
REQ-005 SHALL have ports StackReq (in, 1), StackPop (in, 1; 1 = pop, 0 = push) and StackAck (out, 1): stack requester.
REQ-006 SHALL have ports LoadReq (in, 1), LoadTarget (in, 2; 00/01 = PC, 10 = AR, 11 = SP), LoadData (in, 16) and LoadAck (out, 1): load requester.
REQ-007 SHALL drive the ARF through ArfI (out, 16), ArfRegSel (out, 3; active-low enables, bit2 = PC, bit1 = AR, bit0 = SP), ArfFunSel (out, 3), ArfOutCSel (out, 2) and ArfOutDSel (out, 2).
REQ-008 SHALL have AddrValid (out, 1): ARF OutD holds a valid memory address this cycle.
REQ-009 SHALL have Busy (out, 1): high while initialising or executing an operation.

Function
REQ-010 SHALL use the ARF FunSel codes DEC = 000, INC = 001, LOAD = 010 and CLR = 011, and the select codes PC = 00, AR = 10, SP = 11.
REQ-011 SHALL be a Moore FSM with states INIT_CLR, INIT_SP, IDLE, FETCH, PUSH, POP_INC, POP_ADDR and LOAD; all outputs SHALL decode from the state and the latched request fields only.
REQ-012 In IDLE (defaults): RegSel = 111, FunSel = 000, OutCSel = AR, OutDSel = PC, ArfI = 0, all acks = 0, AddrValid = 0, Busy = 0.
REQ-013 INIT_CLR: RegSel = 000, FunSel = CLR, Busy = 1; goes to INIT_SP.
REQ-014 INIT_SP: RegSel = 110, FunSel = LOAD, ArfI = STACK_TOP, Busy = 1; goes to IDLE.
REQ-015 IDLE: requests sampled each edge; if any is high, the round-robin arbiter grants one port and the grant selects the next state; otherwise stays in IDLE.
REQ-016 The arbiter order SHALL be Fetch -> Stack -> Load; after a grant, priority moves to the port following the granted port.
REQ-017 On grant: StackPop, LoadTarget and LoadData SHALL be latched; later changes to them SHALL not affect the operation.
REQ-018 FETCH (1 cycle): OutDSel = PC, AddrValid = 1, RegSel = 011, FunSel = INC, FetchAck = 1. OutD carries the pre-increment PC.
REQ-019 PUSH (1 cycle, post-decrement): OutDSel = SP, AddrValid = 1, RegSel = 110, FunSel = DEC, StackAck = 1.
REQ-020 POP_INC: RegSel = 110, FunSel = INC, then POP_ADDR: OutDSel = SP, AddrValid = 1, StackAck = 1 (pre-increment, 2 cycles).
REQ-021 LOAD (1 cycle): ArfI = latched LoadData, FunSel = LOAD, RegSel enables only the latched target, LoadAck = 1.
REQ-022 Every operation state SHALL return to IDLE.
  - Each ack is a single-cycle pulse in the final cycle of its operation.
  - A Req still high after its ack is a new request.
REQ-023 Latency: Req high before edge N -> op state from edge N; at most one op per two cycles (IDLE between).
REQ-024 Register values wrap modulo 2^16: PC/SP INC at FFFF -> 0000; SP DEC at 0000 -> FFFF; no flag.
REQ-025 Busy = 1 in every state except IDLE.
REQ-026 Requests arriving during INIT_* or during an op SHALL wait; they are not lost while Req is held.

Reset
REQ-027 Reset low SHALL immediately force state = INIT_CLR and arbiter priority = Fetch, and clear all latched fields; all acks and AddrValid SHALL go to 0 without waiting for a clock.
REQ-028 Reset mid-operation SHALL abandon the operation without an ack; re-initialisation restores PC = 0, AR = 0, SP = STACK_TOP.

Structure
REQ-029 Package arf_ctrl_pkg SHALL hold the FunSel codes, select codes, RegSel masks, state encoding and default STACK_TOP.
REQ-030 Round-robin arbitration SHALL be the sub-module rr_arbiter_3, which holds the priority pointer and has an advance input.

Verification
REQ-031 Reset release -> INIT_CLR, INIT_SP, IDLE; then PC = 0000, AR = 0000, SP = 00FF, Busy low from cycle 3.
REQ-032 FetchReq held 3 ops -> OutD = 0000, 0001, 0002 with AddrValid and FetchAck on alternate cycles; PC = 0003.
REQ-033 Push with SP = 00FF -> OutD = 00FF, SP = 00FE; then pop -> POP_INC then OutD = 00FF, SP = 00FF, StackAck once.
REQ-034 All three Req high in IDLE -> grants in order Fetch, Stack, Load, Fetch; no port is starved.
REQ-035 Load AR = 3548 with LoadData changed after grant -> AR = 3548, PC and SP unchanged; load PC = FFFF then fetch -> PC = 0000.
REQ-036 Reset asserted during POP_INC -> StackAck never pulses; after init, SP = 00FF.
